// File: rtl/mdr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdr_pkg
// Description : Shared definitions for the memory data register.
//               - Access-size encodings: SZ_BYTE, SZ_HALF, SZ_WORD
//                 (2'b11 is treated as a word access).
//               - Transaction state enum: IDLE, RD_WAIT, WR_WAIT.
// Revision    : 1.0 - initial release
// ============================================================================
package mdr_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mdr_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mdr_lane_align
// Description : Combinational byte-lane steering for the MDR.
//               Load side : picks the addressed byte/half out of the read
//                           word, right-justifies it, and sign- or
//                           zero-extends it.
//               Store side: replicates the low byte/half of the register
//                           across every lane and builds the byte enables.
// Ports       : ld_size/ld_sext/ld_off/rdata -> ld_data
//               st_size/st_off/st_q          -> st_wdata, st_be
// Revision    : 1.0 - initial release
// ============================================================================
module mdr_lane_align
    import mdr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [1:0]          ld_size,
    input  logic                ld_sext,
    input  logic [OFF_W-1:0]    ld_off,
    input  logic [DATA_W-1:0]   rdata,
    output logic [DATA_W-1:0]   ld_data,
    input  logic [1:0]          st_size,
    input  logic [OFF_W-1:0]    st_off,
    input  logic [DATA_W-1:0]   st_q,
    output logic [DATA_W-1:0]   st_wdata,
    output logic [DATA_W/8-1:0] st_be
);

    localparam int NB = DATA_W / 8;

    logic [OFF_W-1:0] w_ld_hoff;
    logic [OFF_W-1:0] w_st_hoff;
    logic [7:0]       w_ld_byte;
    logic [15:0]      w_ld_half;

    always_comb begin
        // Halfword accesses are always naturally aligned: offset bit 0 is dropped.
        w_ld_hoff = {ld_off[OFF_W-1:1], 1'b0};
        w_ld_byte = 8'(rdata >> {ld_off, 3'b000});
        w_ld_half = 16'(rdata >> {w_ld_hoff, 3'b000});
        ld_data   = rdata;
        case (ld_size)
            SZ_BYTE: ld_data = {{(DATA_W-8){ld_sext & w_ld_byte[7]}}, w_ld_byte};
            SZ_HALF: ld_data = {{(DATA_W-16){ld_sext & w_ld_half[15]}}, w_ld_half};
            default: ld_data = rdata;
        endcase
    end

    always_comb begin
        w_st_hoff = {st_off[OFF_W-1:1], 1'b0};
        st_wdata  = st_q;
        st_be     = '1;
        case (st_size)
            SZ_BYTE: begin
                st_wdata = {NB{st_q[7:0]}};
                st_be    = NB'(1) << st_off;
            end
            SZ_HALF: begin
                st_wdata = {(NB/2){st_q[15:0]}};
                st_be    = NB'(3) << w_st_hoff;
            end
            default: begin
                st_wdata = st_q;
                st_be    = '1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdr_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : mdr_mem_if
// Description : Memory data register with a req/ack memory port.
//               Loads from the internal bus (MDRin) or runs its own read and
//               write transactions with arbitrary wait states, supporting
//               byte/half/word sizes with sign/zero extension on loads and
//               lane replication on stores. All outputs are registered.
// Ports       : clk, clr (sync, active-high)
//               BusMuxOut, MDRin, Q           - internal bus side
//               rd_start, wr_start, size,
//               sext, byte_off                - transaction control
//               mem_req, mem_we, mem_be,
//               mem_wdata, mem_rdata, mem_ack - memory port
//               busy, done, err               - status
// Config      : `define MDR_TIMEOUT_EN to abort a transaction after
//               TIMEOUT_CYCLES wait cycles without ack (err is sticky until
//               the next start). Undefined: waits forever, err tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mdr_mem_if
    import mdr_pkg::*;
#(
    parameter  int DATA_W         = 32,
    parameter  int TIMEOUT_CYCLES = 15,
    localparam int OFF_W          = $clog2(DATA_W / 8)
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [DATA_W-1:0]   BusMuxOut,
    input  logic                MDRin,
    input  logic                rd_start,
    input  logic                wr_start,
    input  logic [1:0]          size,
    input  logic                sext,
    input  logic [OFF_W-1:0]    byte_off,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [DATA_W-1:0]   Q,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t               r_state;
    logic [1:0]           r_size;
    logic                 r_sext;
    logic [OFF_W-1:0]     r_off;
    logic [DATA_W-1:0]    w_ld_data;
    logic [DATA_W-1:0]    w_st_wdata;
    logic [DATA_W/8-1:0]  w_st_be;

    // Load path uses the attributes latched at start; store path works from
    // the live request so the lanes are ready to register on the start edge.
    mdr_lane_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_lane_align (
        .ld_size  (r_size),
        .ld_sext  (r_sext),
        .ld_off   (r_off),
        .rdata    (mem_rdata),
        .ld_data  (w_ld_data),
        .st_size  (size),
        .st_off   (byte_off),
        .st_q     (Q),
        .st_wdata (w_st_wdata),
        .st_be    (w_st_be)
    );

`ifdef MDR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wait_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= IDLE;
            r_size    <= SZ_BYTE;
            r_sext    <= 1'b0;
            r_off     <= '0;
            Q         <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef MDR_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (rd_start || wr_start) begin
                        r_size  <= size;
                        r_sext  <= sext;
                        r_off   <= byte_off;
                        mem_req <= 1'b1;
                        mem_be  <= w_st_be;
                        busy    <= 1'b1;
                        err     <= 1'b0;
`ifdef MDR_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                        if (rd_start) begin
                            r_state   <= RD_WAIT;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                        end else begin
                            r_state   <= WR_WAIT;
                            mem_we    <= 1'b1;
                            mem_wdata <= w_st_wdata;
                        end
                    end else if (MDRin) begin
                        Q <= BusMuxOut;
                    end
                end

                RD_WAIT, WR_WAIT: begin
                    if (mem_ack) begin
                        if (r_state == RD_WAIT) begin
                            Q <= w_ld_data;
                        end
                        r_state   <= IDLE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
`ifdef MDR_TIMEOUT_EN
                    // The wait cycle that would be the (TIMEOUT_CYCLES+1)th
                    // is never entered: request lasts TIMEOUT_CYCLES cycles.
                    else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= IDLE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mdr_mem_if.md
# mdr_mem_if

Parametrised memory data register with a memory-side request/acknowledge handshake. It is the next generation of the datapath MDR. Besides loading from the bus, it runs its own read and write transactions with variable wait states. It also supports byte, halfword and word accesses, with sign or zero extension on loads and lane replication on stores. It sits between the internal bus (`BusMuxOut` in, `Q` out to bus mux) and the memory port.

## Interface
- DATA_W, 32, register/bus width; multiple of 16, at least 32.
- TIMEOUT_CYCLES, 15, maximum wait cycles before abort; only used with MDR_TIMEOUT_EN.
- OFF_W, log2(DATA_W/8), derived width of the byte-offset input.

Ports:
- clk  in  1  sole clock, rising edge.
- clr  in  1  reset, synchronous, active-high.
- BusMuxOut  in  DATA_W  internal bus data.
- MDRin  in  1  load `Q` from `BusMuxOut`; ignored while busy.
- rd_start  in  1  begin memory read.
- wr_start  in  1  begin memory write of `Q`.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- sext  in  1  sign-extend byte/half loads (0 = zero-extend).
- byte_off  in  OFF_W  byte lane of access.
- mem_req  out  1  transaction request, held until ack or abort.
- mem_we  out  1  1 = write transaction.
- mem_be  out  DATA_W/8  byte enables.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  memory completion, sampled only while mem_req=1.
- Q  out  DATA_W  MDR contents.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag.

## Operation
- States: IDLE, RD_WAIT, WR_WAIT.
- IDLE, priority rd_start > wr_start > MDRin. A start latches size, sext and byte_off, then enters the matching WAIT state. MDRin loads `Q` only when no start is present.
- Both WAIT states: mem_req=1 and busy=1. mem_we=1 in WR_WAIT only. Starts and MDRin are ignored.
- Lane rules:
  - Byte access uses byte_off.
  - Half access uses byte_off with bit0 forced to 0.
  - Word access ignores byte_off; mem_be is all ones.
- Read completion: mem_ack in RD_WAIT captures the selected lanes into `Q`, right-justified. Upper bits are filled with the sign bit when sext=1, else 0. State returns to IDLE.
- Write: mem_wdata is the low byte or half of `Q`, replicated across all lanes (word: `Q` as-is). mem_be is asserted only on the accessed lanes. mem_ack returns to IDLE; `Q` is unchanged.
- A start clears err.

## Timing
- Reset values: Q=0, mem_req=0, mem_we=0, mem_be=0, mem_wdata=0, busy=0, done=0, err=0, state IDLE.
- All outputs are registered.
- A start sampled at edge N gives mem_req=1 from cycle N+1.
- An ack sampled at edge M:
  - mem_req drops, `Q` holds the new value, and done=1, all during cycle M+1.
  - Minimum start-to-`Q`-valid latency is 2 cycles.
- A new start is accepted in the done cycle, giving back-to-back transactions.
- clr mid-transaction: IDLE and all outputs return to reset values at the next edge. A late mem_ack is ignored.
- mem_ack while mem_req=0 is ignored.

## Configuration
- MDR_TIMEOUT_EN defined:
  - A wait counter runs in each WAIT state and is cleared on entry.
  - When the counter reaches TIMEOUT_CYCLES without ack, mem_req drops and state returns to IDLE.
  - err=1 (sticky) and done pulses; `Q` is unchanged.
- MDR_TIMEOUT_EN undefined: the block waits indefinitely, no counter logic is present, and err is tied 0.

## Structure
- Package mdr_pkg holds:
  - the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the state enum (IDLE, RD_WAIT, WR_WAIT).
- Sub-module mdr_lane_align (combinational) holds:
  - load extraction/extension;
  - store replication and mem_be generation.
- The FSM and registers stay in mdr_mem_if.

## Test plan
- Reset then MDRin=1, BusMuxOut=0xDEADBEEF -> Q=0xDEADBEEF next cycle; busy=0, mem_req=0.
- Byte read, byte_off=2, sext=1, mem_rdata=0x0080_0000, ack after 3 wait cycles -> Q=0xFFFFFF80, done pulses once, mem_req held exactly 4 cycles.
- Half write, byte_off=3, Q=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; Q unchanged after ack.
- rd_start and wr_start and MDRin in the same IDLE cycle -> read performed; bus data not loaded.
- clr asserted in RD_WAIT, then mem_ack 1 cycle later -> mem_req=0, Q=0, no done pulse.
- With MDR_TIMEOUT_EN and no ack -> mem_req drops after 15 wait cycles, err=1 and done=1; err cleared by the next rd_start.
